video_timing_gen: RTL and testbench
===================================

// Module: video_timing_gen
// PURPOSE
//  Source end of the pixel-stream interface (de / h_sync / v_sync / 24-bit {R,G,B}) consumed by
//  vp_* processing blocks and hdmi_out. Generates raster timing from counters plus a synthetic
//  test pattern, so pipelines run without hdmi_in file input. Drives the same signal set with
//  the same meaning as a received stream; outputs connect straight to a vp_* block's *_in ports.
// PARAMETERS
//  H_ACTIVE  64  active pixels per line       | H_FP 4 | H_SYNC 8 | H_BP 8   (pixel clocks)
//  V_ACTIVE  48  active lines per frame       | V_FP 2 | V_SYNC 2 | V_BP 4   (lines)
//  HS_POL    1   h_sync_out level during sync pulse (inactive level = ~HS_POL)
//  VS_POL    1   v_sync_out level during sync pulse
//  CNT_W     12  width of x/y counters; must hold H_TOTAL-1 and V_TOTAL-1
// PORTS
//  clk          in   1   pixel clock
//  rst_n        in   1   asynchronous reset, active low
//  en           in   1   clock enable; 0 freezes counters and all outputs
//  pattern_sel  in   2   0 colour bars, 1 grey ramp, 2 8x8 checker, 3 frame-cycling solid colour
//  de_out       out  1   data enable, high on active pixels
//  h_sync_out   out  1   horizontal sync
//  v_sync_out   out  1   vertical sync
//  pixel_out    out  24  {R[23:16],G[15:8],B[7:0]}; 0 when de_out=0
//  x_out        out  CNT_W  horizontal counter of the emitted pixel
//  y_out        out  CNT_W  vertical counter of the emitted pixel
//  frame_start  out  1   one-cycle pulse with pixel (0,0)
// BEHAVIOUR
//  - One clock; reset asynchronous and active low. All outputs registered.
//  - Reset: h_cnt=v_cnt=0, frame_cnt=0, de_out=0, frame_start=0, pixel_out=0, x_out=y_out=0,
//    h_sync_out=~HS_POL, v_sync_out=~VS_POL, pattern latch=0.
//  - H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP (84); V_TOTAL likewise (56). Frame = 4704 clocks.
//  - Line order: active, front porch, sync, back porch; frame order identical in lines.
//  - h_cnt wraps H_TOTAL-1 -> 0 and increments v_cnt; v_cnt wraps V_TOTAL-1 -> 0; frame_cnt
//    (8 bit) increments on that wrap, rolls 255 -> 0.
//  - Latency 1: outputs on cycle n+1 describe counter state (h,v) of enabled cycle n.
//    de = h<H_ACTIVE && v<V_ACTIVE; hsync active for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC;
//    vsync active for whole lines V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC, edges aligned to h=0.
//  - First enabled edge after reset emits pixel (0,0): de_out=1, frame_start=1.
//  - pattern_sel is latched only when (h,v)=(0,0) is processed; mid-frame changes take effect
//    next frame (no tearing). Latched value applies to the whole frame including pixel (0,0).
//  - Patterns (x,y = counters): 0: bar=x/(H_ACTIVE/8), colour {bar[2]?FF:00, bar[1]?FF:00,
//    bar[0]?FF:00} reversed so bar 0 is white, bar 7 black; 1: R=G=B=x[7:0] scaled none;
//    2: (x[3]^y[3]) ? FFFFFF : 000000; 3: {frame_cnt, ~frame_cnt, frame_cnt}.
//  - en=0: no counter advance, every output holds its last value (including frame_start pulse).
//  - Reset asserted mid-frame: immediate return to reset values; next frame restarts at (0,0).
//  - Parameters are static; no runtime reconfiguration.
// STRUCTURE
//  - video_timing_pkg: pattern_sel encodings (PAT_BARS/RAMP/CHECK/SOLID), RGB24 width constant,
//    helper function computing totals from porch/sync parameters.
//  - Sub-module video_pattern_gen: combinational pixel from (x,y,frame_cnt,pattern); top holds
//    counters, sync decode, pattern latch and output registers.
// TESTING
//  - Reset, en=1 for 4704 clocks -> exactly 3072 de_out cycles, 56 h_sync pulses of 8 clocks,
//    one v_sync pulse of 168 clocks, one frame_start, at cycle 1 after reset release.
//  - Polarity: HS_POL=0,VS_POL=0 -> syncs idle high, pulse low; during reset both read 1.
//  - pattern_sel=0 -> pixel(0,0)=FFFFFF, pixel(63,0)=000000, bar edges at x=8,16,...;
//    pattern_sel=2 -> pixel(8,0)=FFFFFF, pixel(8,8)=000000; de=0 cycles give pixel_out=0.
//  - Switch pattern_sel 0->1 at y=10 -> frame unchanged to end; next frame pixel(5,0)=050505.
//  - Toggle en low 20 clocks mid-line -> outputs frozen, timing resumes with no lost/extra pixel.
//  - Assert rst_n low at (h=40,v=30) for 3 clocks -> outputs reset asynchronously; after release
//    first output is pixel (0,0) with frame_start=1; 256 frames pattern 3 -> frame_cnt wraps to 0.

Source files
------------

// File: rtl/video_timing_pkg.sv
// Shared definitions for the synthetic video source: pattern encodings,
// pixel width and a helper that sums a line or frame from its segments.
package video_timing_pkg;

    localparam int RGB_W = 24;

    typedef enum logic [1:0] {
        PAT_BARS  = 2'd0,
        PAT_RAMP  = 2'd1,
        PAT_CHECK = 2'd2,
        PAT_SOLID = 2'd3
    } pattern_e;

    // Total length of a line (pixels) or frame (lines) from its four segments.
    function automatic int calc_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/video_pattern_gen.sv
// Combinational test-pattern source: turns the raster position, the frame
// counter and the selected pattern into one 24-bit {R,G,B} pixel.
module video_pattern_gen
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE = 64,
    parameter int CNT_W    = 12
) (
    input  logic [CNT_W-1:0] x_i,
    input  logic [CNT_W-1:0] y_i,
    input  logic [7:0]       frame_cnt_i,
    input  pattern_e         pattern_i,
    output logic [RGB_W-1:0] pixel_o
);

    // Eight equal-width bars span the active line.
    localparam logic [CNT_W-1:0] BAR_W = CNT_W'(H_ACTIVE / 8);

    logic [CNT_W-1:0] bar_full;
    logic [2:0]       bar;
    logic [2:0]       bar_rgb;
    logic             unused_bits;

    assign bar_full = x_i / BAR_W;
    assign bar      = bar_full[2:0];
    // Bar index is inverted so bar 0 is white and bar 7 is black.
    assign bar_rgb  = ~bar;

    // Only bit 3 of y and the low bar bits carry meaning; the rest is ignored.
    assign unused_bits = ^{y_i[CNT_W-1:4], y_i[2:0], bar_full[CNT_W-1:3]};

    // Select the pixel colour for the requested pattern.
    always_comb begin
        pixel_o = '0;
        unique case (pattern_i)
            PAT_BARS:  pixel_o = {{8{bar_rgb[2]}}, {8{bar_rgb[1]}}, {8{bar_rgb[0]}}};
            PAT_RAMP:  pixel_o = {x_i[7:0], x_i[7:0], x_i[7:0]};
            PAT_CHECK: pixel_o = (x_i[3] ^ y_i[3]) ? 24'hFFFFFF : 24'h000000;
            PAT_SOLID: pixel_o = {frame_cnt_i, ~frame_cnt_i, frame_cnt_i};
            default:   pixel_o = '0;
        endcase
    end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing and test-pattern source for the pixel-stream interface.
// Counters walk the frame, sync/enable are decoded from them, and every
// output is registered so it describes the counter state one clock earlier.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int   H_ACTIVE = 64,
    parameter int   H_FP     = 4,
    parameter int   H_SYNC   = 8,
    parameter int   H_BP     = 8,
    parameter int   V_ACTIVE = 48,
    parameter int   V_FP     = 2,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 4,
    parameter logic HS_POL   = 1'b1,
    parameter logic VS_POL   = 1'b1,
    parameter int   CNT_W    = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       pattern_sel,
    output logic             de_out,
    output logic             h_sync_out,
    output logic             v_sync_out,
    output logic [RGB_W-1:0] pixel_out,
    output logic [CNT_W-1:0] x_out,
    output logic [CNT_W-1:0] y_out,
    output logic             frame_start
);

    localparam int H_TOTAL = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [CNT_W-1:0] h_q, h_d;
    logic [CNT_W-1:0] v_q, v_d;
    logic [7:0]       frame_q, frame_d;
    pattern_e         pat_q, pat_d;

    logic             de_q, de_d;
    logic             hs_q, hs_d;
    logic             vs_q, vs_d;
    logic [RGB_W-1:0] pix_q, pix_d;
    logic [CNT_W-1:0] x_q, y_q;
    logic             fs_q, fs_d;

    logic             origin;
    logic [RGB_W-1:0] pat_pixel;

    assign origin = (h_q == '0) && (v_q == '0);

    // Pattern is sampled only at the frame origin so a frame never tears;
    // the origin pixel itself already uses the newly sampled value.
    assign pat_d = origin ? pattern_e'(pattern_sel) : pat_q;

    video_pattern_gen #(
        .H_ACTIVE (H_ACTIVE),
        .CNT_W    (CNT_W)
    ) u_pattern (
        .x_i         (h_q),
        .y_i         (v_q),
        .frame_cnt_i (frame_q),
        .pattern_i   (pat_d),
        .pixel_o     (pat_pixel)
    );

    // Next raster position: pixel wraps into the next line, line into the next frame.
    always_comb begin
        h_d     = h_q + 1'b1;
        v_d     = v_q;
        frame_d = frame_q;
        if (h_q == H_LAST) begin
            h_d = '0;
            if (v_q == V_LAST) begin
                v_d     = '0;
                frame_d = frame_q + 8'd1;
            end else begin
                v_d = v_q + 1'b1;
            end
        end
    end

    // Decode enable, syncs and pixel for the position being processed now.
    always_comb begin
        de_d  = (h_q < H_ACT_C) && (v_q < V_ACT_C);
        hs_d  = ((h_q >= HS_START) && (h_q < HS_END)) ? HS_POL : ~HS_POL;
        vs_d  = ((v_q >= VS_START) && (v_q < VS_END)) ? VS_POL : ~VS_POL;
        pix_d = de_d ? pat_pixel : '0;
        fs_d  = origin;
    end

    // Raster counters, frame counter and latched pattern; frozen while en is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q     <= '0;
            v_q     <= '0;
            frame_q <= '0;
            pat_q   <= PAT_BARS;
        end else if (en) begin
            h_q     <= h_d;
            v_q     <= v_d;
            frame_q <= frame_d;
            pat_q   <= pat_d;
        end
    end

    // Output registers: one clock behind the counters, held while en is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            de_q  <= 1'b0;
            hs_q  <= ~HS_POL;
            vs_q  <= ~VS_POL;
            pix_q <= '0;
            x_q   <= '0;
            y_q   <= '0;
            fs_q  <= 1'b0;
        end else if (en) begin
            de_q  <= de_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
            pix_q <= pix_d;
            x_q   <= h_q;
            y_q   <= v_q;
            fs_q  <= fs_d;
        end
    end

    assign de_out      = de_q;
    assign h_sync_out  = hs_q;
    assign v_sync_out  = vs_q;
    assign pixel_out   = pix_q;
    assign x_out       = x_q;
    assign y_out       = y_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: a full-size instance and a tiny, inverted-polarity
// instance run side by side; a reference raster model queues the expected
// output of every clock and each DUT output is popped and compared.
module tb_video_timing_gen;

    typedef struct packed {
        logic        de;
        logic        hs;
        logic        vs;
        logic [23:0] pix;
        logic [11:0] x;
        logic [11:0] y;
        logic        fs;
    } out_t;

    logic        clk = 1'b0;
    logic        rstMain, rstSmall, enMain, enSmall;
    logic [1:0]  selMain, selSmall;

    logic        deM, hsM, vsM, fsM, deS, hsS, vsS, fsS;
    logic [23:0] pixM, pixS;
    logic [11:0] xM, yM, xS, yS;

    int vectors = 0;
    int miscompares = 0;
    int blankPixErr = 0;

    // Model geometry and state, index 0 = full-size DUT, 1 = tiny DUT.
    int hAct[2], hFp[2], hSyn[2], hBp[2], vAct[2], vFp[2], vSyn[2], vBp[2];
    bit hPol[2], vPol[2];
    int mh[2], mv[2], mframe[2], mpat[2], procH[2], procV[2];
    out_t lastExp[2];
    out_t expQ0[$];
    out_t expQ1[$];

    always #5 clk = ~clk;

    video_timing_gen dutMain (
        .clk(clk), .rst_n(rstMain), .en(enMain), .pattern_sel(selMain),
        .de_out(deM), .h_sync_out(hsM), .v_sync_out(vsM), .pixel_out(pixM),
        .x_out(xM), .y_out(yM), .frame_start(fsM)
    );

    video_timing_gen #(
        .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .CNT_W(12)
    ) dutSmall (
        .clk(clk), .rst_n(rstSmall), .en(enSmall), .pattern_sel(selSmall),
        .de_out(deS), .h_sync_out(hsS), .v_sync_out(vsS), .pixel_out(pixS),
        .x_out(xS), .y_out(yS), .frame_start(fsS)
    );

    task automatic checkVec(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] patPix(input int pat, input int x, input int y, input int f, input int ha);
        logic [23:0] p;
        logic [7:0]  b;
        int          bar;
        p = 24'h0;
        case (pat)
            0: begin
                bar = x / (ha / 8);
                case (bar)
                    0: p = 24'hFFFFFF;
                    1: p = 24'hFFFF00;
                    2: p = 24'hFF00FF;
                    3: p = 24'hFF0000;
                    4: p = 24'h00FFFF;
                    5: p = 24'h00FF00;
                    6: p = 24'h0000FF;
                    default: p = 24'h000000;
                endcase
            end
            1: begin
                b = x[7:0];
                p = {b, b, b};
            end
            2: p = ((((x >> 3) ^ (y >> 3)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
            default: begin
                b = f[7:0];
                p = {b, ~b, b};
            end
        endcase
        return p;
    endfunction

    function automatic out_t resetOut(input int d);
        out_t o;
        o = '0;
        o.hs = !hPol[d];
        o.vs = !vPol[d];
        return o;
    endfunction

    function automatic out_t modelOut(input int d, input int sel);
        out_t o;
        int   pat;
        int   hsLo, vsLo;
        pat  = (mh[d] == 0 && mv[d] == 0) ? sel : mpat[d];
        hsLo = hAct[d] + hFp[d];
        vsLo = vAct[d] + vFp[d];
        o.de  = (mh[d] < hAct[d]) && (mv[d] < vAct[d]);
        o.hs  = (mh[d] >= hsLo && mh[d] < hsLo + hSyn[d]) ? hPol[d] : !hPol[d];
        o.vs  = (mv[d] >= vsLo && mv[d] < vsLo + vSyn[d]) ? vPol[d] : !vPol[d];
        o.pix = o.de ? patPix(pat, mh[d], mv[d], mframe[d], hAct[d]) : 24'h0;
        o.x   = 12'(mh[d]);
        o.y   = 12'(mv[d]);
        o.fs  = (mh[d] == 0 && mv[d] == 0);
        return o;
    endfunction

    task automatic resetModel(input int d);
        mh[d] = 0;
        mv[d] = 0;
        mframe[d] = 0;
        mpat[d] = 0;
    endtask

    task automatic advanceModel(input int d, input int sel);
        if (mh[d] == 0 && mv[d] == 0) mpat[d] = sel;
        mh[d]++;
        if (mh[d] == hAct[d] + hFp[d] + hSyn[d] + hBp[d]) begin
            mh[d] = 0;
            mv[d]++;
            if (mv[d] == vAct[d] + vFp[d] + vSyn[d] + vBp[d]) begin
                mv[d] = 0;
                mframe[d] = (mframe[d] + 1) % 256;
            end
        end
    endtask

    // Pop one expected vector per DUT and compare with what the DUT shows now.
    task automatic checkOutput();
        out_t o0, o1, e;
        o0 = {deM, hsM, vsM, pixM, xM, yM, fsM};
        o1 = {deS, hsS, vsS, pixS, xS, yS, fsS};
        if (expQ0.size() == 0 || expQ1.size() == 0) begin
            checkVec("scoreboard_empty", 64'(expQ0.size() + expQ1.size()), 64'd2);
        end else begin
            e = expQ0.pop_front();
            checkVec("main_vec", 64'(o0), 64'(e));
            e = expQ1.pop_front();
            checkVec("small_vec", 64'(o1), 64'(e));
        end
        if (!deM && pixM != 24'h0) blankPixErr++;
    endtask

    // Queue what each DUT must show after the coming edge, then clock and check.
    task automatic applyStimulus();
        out_t e;
        for (int d = 0; d < 2; d++) begin
            logic rstLow, enD;
            int   sel;
            rstLow = (d == 0) ? !rstMain : !rstSmall;
            enD    = (d == 0) ? enMain : enSmall;
            sel    = (d == 0) ? int'(selMain) : int'(selSmall);
            if (rstLow) begin
                e = resetOut(d);
                resetModel(d);
            end else if (enD) begin
                e = modelOut(d, sel);
                procH[d] = mh[d];
                procV[d] = mv[d];
                advanceModel(d, sel);
            end else begin
                e = lastExp[d];
            end
            lastExp[d] = e;
            if (d == 0) expQ0.push_back(e);
            else        expQ1.push_back(e);
        end
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    // Clock until DUT d has just emitted pixel (x,y) of frame f (f<0: any frame).
    task automatic runTo(input int d, input int x, input int y, input int f, input int budget);
        int n;
        bit hit;
        n = 0;
        hit = 0;
        while (!hit && n < budget) begin
            hit = (mh[d] == x && mv[d] == y && (f < 0 || mframe[d] == f));
            applyStimulus();
            n++;
        end
        checkVec("runTo_reached", 64'(hit), 64'd1);
    endtask

    initial begin
        int deCnt, hsCyc, hsPulses, vsCyc, vsPulses, fsCnt;
        logic hsPrev, vsPrev;

        hAct[0] = 64; hFp[0] = 4; hSyn[0] = 8; hBp[0] = 8;
        vAct[0] = 48; vFp[0] = 2; vSyn[0] = 2; vBp[0] = 4;
        hPol[0] = 1;  vPol[0] = 1;
        hAct[1] = 8;  hFp[1] = 1; hSyn[1] = 2; hBp[1] = 1;
        vAct[1] = 4;  vFp[1] = 1; vSyn[1] = 1; vBp[1] = 1;
        hPol[1] = 0;  vPol[1] = 0;

        rstMain = 0; rstSmall = 0; enMain = 0; enSmall = 0;
        selMain = 2'd0; selSmall = 2'd3;
        for (int d = 0; d < 2; d++) begin
            resetModel(d);
            lastExp[d] = resetOut(d);
            procH[d] = -1;
            procV[d] = -1;
        end

        // Reset state, including the inverted-polarity idle level.
        repeat (3) applyStimulus();
        checkVec("rst_de", 64'(deM), 64'd0);
        checkVec("rst_hs_main", 64'(hsM), 64'd0);
        checkVec("rst_vs_main", 64'(vsM), 64'd0);
        checkVec("rst_hs_small", 64'(hsS), 64'd1);
        checkVec("rst_vs_small", 64'(vsS), 64'd1);

        @(negedge clk);
        rstMain = 1; rstSmall = 1; enMain = 1; enSmall = 1;

        // First full frame: colour bars, aggregate timing counts.
        deCnt = 0; hsCyc = 0; hsPulses = 0; vsCyc = 0; vsPulses = 0; fsCnt = 0;
        hsPrev = 1'b0; vsPrev = 1'b0;
        for (int i = 0; i < 4704; i++) begin
            applyStimulus();
            if (i == 0) begin
                checkVec("first_de", 64'(deM), 64'd1);
                checkVec("first_fs", 64'(fsM), 64'd1);
                checkVec("first_pix", 64'(pixM), 64'hFFFFFF);
            end
            deCnt += int'(deM);
            hsCyc += int'(hsM);
            vsCyc += int'(vsM);
            fsCnt += int'(fsM);
            if (hsM && !hsPrev) hsPulses++;
            if (vsM && !vsPrev) vsPulses++;
            hsPrev = hsM;
            vsPrev = vsM;
            if (procH[0] == 63 && procV[0] == 0) checkVec("bar_last", 64'(pixM), 64'h000000);
            if (procH[0] == 7  && procV[0] == 0) checkVec("bar0_end", 64'(pixM), 64'hFFFFFF);
            if (procH[0] == 8  && procV[0] == 0) checkVec("bar1_edge", 64'(pixM), 64'hFFFF00);
            if (procH[0] == 16 && procV[0] == 0) checkVec("bar2_edge", 64'(pixM), 64'hFF00FF);
            if (procH[0] == 0  && procV[0] == 10) selMain = 2'd1;
            if (procH[0] == 8  && procV[0] == 20) checkVec("no_tear", 64'(pixM), 64'hFFFF00);
        end
        checkVec("de_count", 64'(deCnt), 64'd3072);
        checkVec("hs_pulses", 64'(hsPulses), 64'd56);
        checkVec("hs_cycles", 64'(hsCyc), 64'd448);
        checkVec("vs_pulses", 64'(vsPulses), 64'd1);
        checkVec("vs_cycles", 64'(vsCyc), 64'd168);
        checkVec("fs_count", 64'(fsCnt), 64'd1);

        // Frame 1: grey ramp picked up at the frame boundary.
        runTo(0, 5, 0, -1, 200);
        checkVec("ramp_5_0", 64'(pixM), 64'h050505);
        runTo(0, 30, 20, -1, 5000);
        checkVec("ramp_30_20", 64'(pixM), 64'h1E1E1E);
        selMain = 2'd2;

        // Frame 2: checkerboard.
        runTo(0, 8, 0, -1, 5000);
        checkVec("check_8_0", 64'(pixM), 64'hFFFFFF);
        runTo(0, 8, 8, -1, 5000);
        checkVec("check_8_8", 64'(pixM), 64'h000000);

        // Clock enable held low mid-line: outputs freeze, no pixel lost.
        runTo(0, 30, 10, -1, 5000);
        enMain = 0;
        repeat (20) applyStimulus();
        checkVec("freeze_x", 64'(xM), 64'd30);
        checkVec("freeze_y", 64'(yM), 64'd10);
        enMain = 1;
        applyStimulus();
        checkVec("resume_x", 64'(xM), 64'd31);
        checkVec("resume_y", 64'(yM), 64'd10);
        selMain = 2'd3;

        // Asynchronous reset mid-frame, then restart at the origin.
        runTo(0, 40, 30, -1, 5000);
        #2;
        rstMain = 0;
        #1;
        checkVec("async_rst_de", 64'(deM), 64'd0);
        checkVec("async_rst_x", 64'(xM), 64'd0);
        checkVec("async_rst_y", 64'(yM), 64'd0);
        checkVec("async_rst_pix", 64'(pixM), 64'd0);
        repeat (3) applyStimulus();
        @(negedge clk);
        rstMain = 1;
        applyStimulus();
        checkVec("restart_fs", 64'(fsM), 64'd1);
        checkVec("restart_x", 64'(xM), 64'd0);
        checkVec("restart_pix", 64'(pixM), 64'h00FF00);

        // Tiny instance: frame counter runs through 255 and wraps to 0.
        runTo(1, 0, 0, 255, 30000);
        checkVec("small_f255", 64'(pixS), 64'hFF00FF);
        runTo(1, 0, 0, -1, 200);
        checkVec("small_wrap", 64'(pixS), 64'h00FF00);

        checkVec("blank_pix_zero", 64'(blankPixErr), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
